// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: the synchronous-read instruction memory port plus
// the presentation signals handed to decode.
// master = fetch stage, slave = imem/decode side.
interface if_fetch_stage_if #(
  parameter int IMEM_AW = 10
) ();
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_rdata_i;
  logic               id_valid_o;
  logic [31:0]        id_pc_o;
  logic [31:0]        id_instr_o;
  logic [31:0]        id_pc4_o;

  modport master (
    output imem_addr_o,
    input  imem_rdata_i,
    output id_valid_o,
    output id_pc_o,
    output id_instr_o,
    output id_pc4_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_rdata_i,
    input  id_valid_o,
    input  id_pc_o,
    input  id_instr_o,
    input  id_pc4_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and drives a 1-cycle-latency imem.
// The fetched word is presented to decode together with its PC and PC+4.
// A misaligned redirect parks the stage in a sticky FAULT state.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall counters.
//
// state | meaning
// BOOT  | first cycle after reset, fetching the word at PC_RESET
// RUN   | normal fetch; the presented instruction is valid
// FAULT | misaligned redirect seen; frozen until reset
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IMEM_AW  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [31:0]           redirect_pc_i,
  if_fetch_stage_if.master      bus,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]           perf_fetch_o,
  output logic [31:0]           perf_stall_o,
`endif
  output logic                  fault_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc;
  logic        redirect_ok;
  logic        fetch_ev;
  logic        stall_ev;

  // Byte address -> imem word index relative to PC_RESET; wraps silently.
  function automatic logic [IMEM_AW-1:0] word_idx(input logic [31:0] a);
    return IMEM_AW'((a - PC_RESET) >> 2);
  endfunction

  assign redirect_ok = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state / next-PC selection and the combinational imem address.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    npc              = pc_q;
    fetch_ev         = 1'b0;
    stall_ev         = 1'b0;
    bus.imem_addr_o  = word_idx(pc_q);
    case (state_q)
      BOOT: begin
        // Inputs ignored: the first fetch is always PC_RESET.
        state_d         = RUN;
        pc_d            = PC_RESET;
        bus.imem_addr_o = word_idx(PC_RESET);
      end
      RUN: begin
        if (redirect_ok) begin
          npc      = redirect_pc_i;
          fetch_ev = 1'b1;
        end else if (redirect_valid_i) begin
          // Misaligned target: keep the last good PC and stop.
          npc     = pc_q;
          state_d = FAULT;
        end else if (stall_i) begin
          npc      = pc_q;
          stall_ev = 1'b1;
        end else begin
          npc      = pc_q + 32'd4;
          fetch_ev = 1'b1;
        end
        pc_d            = npc;
        bus.imem_addr_o = word_idx(npc);
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
        pc_d    = PC_RESET;
      end
    endcase
  end

  // Decode-facing outputs; instruction is forced to a NOP when not valid.
  always_comb begin
    bus.id_valid_o = (state_q == RUN);
    bus.id_pc_o    = pc_q;
    bus.id_pc4_o   = pc_q + 32'd4;
    bus.id_instr_o = (state_q == RUN) ? bus.imem_rdata_i : 32'h0;
    fault_o        = (state_q == FAULT);
  end

`ifdef IF_PERF_CNT_EN
  // Saturating performance counters; a redirect counts as a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_o <= 32'h0;
      perf_stall_o <= 32'h0;
    end else begin
      if (fetch_ev && (perf_fetch_o != 32'hFFFF_FFFF))
        perf_fetch_o <= perf_fetch_o + 32'd1;
      if (stall_ev && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`else
  // Event strobes only feed the optional counters.
  logic unused_ev;
  assign unused_ev = fetch_ev ^ stall_ev;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with an imem model whose word k
// holds 32'h1000_0000 + k, a reference model of the fetch PC, and a queue of
// expected post-edge decode outputs.
module tb_if_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IMEM_AW  = 10;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  if_fetch_stage_if #(.IMEM_AW(IMEM_AW)) bus ();

  if_fetch_stage #(.PC_RESET(PC_RESET), .IMEM_AW(IMEM_AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .bus              (bus),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_o     (perf_fetch),
    .perf_stall_o     (perf_stall),
`endif
    .fault_o          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one cycle latency.
  always @(posedge clk) bus.imem_rdata_i <= 32'h1000_0000 + 32'(bus.imem_addr_o);

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 = BOOT, 1 = RUN, 2 = FAULT.
  int          m_state;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [IMEM_AW-1:0] ref_idx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - PC_RESET) >> 2;
    return d[IMEM_AW-1:0];
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = PC_RESET;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(bus.id_valid_o), 32'd0);
    check({tag, "_pc"},    bus.id_pc_o,         PC_RESET);
    check({tag, "_pc4"},   bus.id_pc4_o,        PC_RESET + 32'd4);
    check({tag, "_instr"}, bus.id_instr_o,      32'd0);
    check({tag, "_fault"}, 32'(fault),          32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr_o), 32'd0);
  endtask

  // One clock cycle: drive inputs, check the combinational address, push the
  // model's expected post-edge outputs, then compare after the edge.
  task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
    logic [IMEM_AW-1:0] exp_addr;
    exp_t e, got_e;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    case (m_state)
      0: begin
        exp_addr = ref_idx(PC_RESET);
        m_state  = 1;
        m_pc     = PC_RESET;
      end
      1: begin
        if (rv && rpc[1:0] == 2'b00) m_pc = rpc;
        else if (rv) m_state = 2;
        else if (!s) m_pc = m_pc + 32'd4;
        exp_addr = ref_idx(m_pc);
      end
      default: exp_addr = ref_idx(m_pc);
    endcase
    check("imem_addr", 32'(bus.imem_addr_o), 32'(exp_addr));
    e.valid = (m_state == 1);
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.instr = (m_state == 1) ? 32'h1000_0000 + 32'(ref_idx(m_pc)) : 32'd0;
    e.fault = (m_state == 2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check("valid", 32'(bus.id_valid_o), 32'(got_e.valid));
    check("pc",    bus.id_pc_o,         got_e.pc);
    check("pc4",   bus.id_pc4_o,        got_e.pc4);
    check("instr", bus.id_instr_o,      got_e.instr);
    check("fault", 32'(fault),          32'(got_e.fault));
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Straight-line fetch from reset.
    step(1'b0, 1'b0, 32'h0);
    check("first_pc",    bus.id_pc_o,    32'h0000_3000);
    check("first_instr", bus.id_instr_o, 32'h1000_0000);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("pc_3008", bus.id_pc_o, 32'h0000_3008);

    // Three stalled cycles at 3008.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("stall_instr", bus.id_instr_o, 32'h1000_0002);
    step(1'b0, 1'b0, 32'h0);
    check("after_stall", bus.id_pc_o, 32'h0000_300C);
    step(1'b0, 1'b0, 32'h0);

    // Redirect together with stall: redirect wins.
    step(1'b1, 1'b1, 32'h0000_3040);
    check("redir_pc",    bus.id_pc_o,    32'h0000_3040);
    check("redir_instr", bus.id_instr_o, 32'h1000_0010);
    check("redir_pc4",   bus.id_pc4_o,   32'h0000_3044);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.id_pc4_o, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_pc", bus.id_pc_o, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Random mix of stalls and aligned redirects.
    for (int i = 0; i < 60; i++) begin
      logic s, rv;
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 5) == 0);
      step(s, rv, PC_RESET + 32'($urandom_range(0, 1023)) * 32'd4);
    end

    // Misaligned redirect: sticky fault, inputs ignored afterwards.
    step(1'b0, 1'b1, 32'h0000_3042);
    check("fault_set", 32'(fault), 32'd1);
    step(1'b0, 1'b1, 32'h0000_3080);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Reset pulse mid-cycle, independent of the clock edge.
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_values("async_reset");
    rst_n = 1'b1;

    // BOOT ignores a simultaneous stall and (misaligned) redirect.
    step(1'b1, 1'b1, 32'h0000_3042);
    check("boot_pc", bus.id_pc_o, PC_RESET);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Reset mid-run, then perf counter scenario from a clean start.
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset2");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_3020);
    step(1'b0, 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch, 32'd6);
    check("perf_stall", perf_stall, 32'd2);
    rst_n = 1'b0;
    #2;
    check("perf_fetch_rst", perf_fetch, 32'd0);
    check("perf_stall_rst", perf_stall, 32'd0);
    rst_n = 1'b1;
    model_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the lab MIPS CPU, sitting directly upstream of decode inside top. It owns the PC register and drives the synchronous-read instruction memory (1-cycle read latency). It presents {valid, pc, instr, pc+4} to decode and accepts stall and redirect (branch/jump) requests from later stages. A misaligned redirect parks the stage in a sticky fault state.

Parameters:
PC_RESET, 32'h0000_3000, PC after reset; imem word 0 maps to this address.
IMEM_AW, 10, instruction memory word-address width (1K words).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hold current fetch, outputs frozen
redirect_valid_i  input  1  load redirect_pc_i as next fetch PC
redirect_pc_i  input  32  redirect target byte address
imem_addr_o  output  IMEM_AW  word address to sync-read imem (combinational)
imem_rdata_i  input  32  imem data, valid 1 cycle after address
id_valid_o  output  1  decode outputs hold a real instruction
id_pc_o  output  32  PC of presented instruction
id_instr_o  output  32  presented instruction (= imem_rdata_i, gated to 0 when !id_valid_o)
id_pc4_o  output  32  id_pc_o + 4, mod 2^32
fault_o  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc_q=PC_RESET, id_valid_o=0, fault_o=0; id_pc_o=PC_RESET, id_pc4_o=PC_RESET+4, id_instr_o=0.
- Word index: idx(a) = (a - PC_RESET) >> 2, truncated to IMEM_AW bits (wraps silently).
- FSM states: BOOT, RUN, FAULT.
- BOOT: imem_addr_o=idx(PC_RESET); stall_i and redirect ignored; next edge -> RUN, valid=1, pc_q=PC_RESET. First valid instruction appears on the first edge after reset release.
- RUN, next-PC priority: (1) redirect_valid_i with redirect_pc_i[1:0]==0 -> npc=redirect_pc_i; (2) stall_i -> npc=pc_q; (3) else npc=pc_q+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- RUN: imem_addr_o=idx(npc) combinationally; on edge pc_q<=npc, valid stays 1. Latency: a redirect in cycle N gives id_pc_o=target with its instruction in cycle N+1.
- Redirect during stall: redirect wins; stall affects only non-redirect cycles.
- Squash: the instruction presented in a redirect cycle is wrong-path. Decode/EX discard it; this stage does not retract it.
- Misaligned redirect (redirect_valid_i=1, redirect_pc_i[1:0]!=0): next edge -> FAULT, fault_o=1, id_valid_o=0, pc_q holds the last good PC.
- FAULT: absorbing until reset. imem_addr_o=idx(pc_q); all inputs ignored.
- id_instr_o=0 whenever id_valid_o=0 (BOOT, FAULT), so decode sees a NOP.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined: adds ports perf_fetch_o[31:0] and perf_stall_o[31:0], both reset to 0.
  - perf_fetch_o increments on each RUN edge with no stall or redirect (a redirect counts as a fetch).
  - perf_stall_o increments on each RUN edge with stall_i=1 and no redirect.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Release rst_n, no stall, imem word k=32'h1000_0000+k -> cycle 1 after release: valid=1, pc=3000, instr=10000000; then pc 3004, 3008 with instr 10000001, 10000002.
2. At pc=3008 assert stall_i for 3 cycles -> pc/instr held at 3008/10000002 for 3 cycles, imem_addr_o=2 throughout; next cycle pc=300C.
3. At pc=3010 assert redirect_valid_i with pc=3040 and stall_i=1 simultaneously -> next cycle pc=3040, instr=10000010, pc4=3044.
4. Redirect to 32'hFFFF_FFFC then run 2 cycles -> pc FFFFFFFC then 00000000; pc4 of first is 0; imem_addr_o = truncated wrap index.
5. Redirect to 32'h0000_3042 -> next cycle fault_o=1, id_valid_o=0, id_instr_o=0; later redirects/stalls ignored; rst_n pulse clears to BOOT.
6. With IF_PERF_CNT_EN: 5 fetches, 2 stalls, 1 redirect -> perf_fetch_o=6, perf_stall_o=2; asynchronous reset -> both 0.
